// File: rtl/team_06_delay_line_ctrl_pkg.sv
// team_06_pkg: shared types and constants for the delay-line controller.
//   state_e    - transaction FSM states
//   SAMPLE_W   - audio sample width in bits
//   AUDIO_ZERO - mid-scale (silence) value for unsigned 8-bit audio
package team_06_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] AUDIO_ZERO = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    WR_REQ,
    DONE
  } state_e;

endpackage

// File: rtl/team_06_delay_line_ctrl.sv
// team_06_delay_line_ctrl: circular-buffer delay line kept in external SRAM.
// Each sample_valid runs one read (the sample written d periods ago) and,
// when save_en is set, one write of save_audio at the current write slot.
//   clk, nrst               - clock, asynchronous active-low reset
//   sample_valid/save_audio - new sample strobe and byte to store
//   save_en                 - 0 skips the SRAM write for this period
//   delay_samples           - requested delay (0 behaves as 1)
//   flush                   - clears buffer history and overrun
//   mem_*                   - SRAM request/ack bus, byte addressed
//   past_output/good_data   - delayed sample and its validity
//   busy/overrun            - transaction in progress / sticky drop flag
module team_06_delay_line_ctrl
  import team_06_pkg::*;
#(
  parameter int unsigned          PTR_W     = 12,
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] save_audio,
  input  logic                save_en,
  input  logic [PTR_W-1:0]    delay_samples,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic [SAMPLE_W-1:0] past_output,
  output logic                good_data,
  output logic                busy,
  output logic                overrun
);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      dly_q, dly_d;
  logic [PTR_W:0]        fill_q, fill_d;
  logic [SAMPLE_W-1:0]   byte_q, byte_d;
  logic [SAMPLE_W-1:0]   rdata_q, rdata_d;
  logic                  save_en_q, save_en_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [SAMPLE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SAMPLE_W-1:0]   past_output_q, past_output_d;
  logic                  good_data_q, good_data_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic [PTR_W-1:0]      dly_in_eff;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  hist_ok;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [PTR_W-1:0] p);
    return BASE_ADDR + ADDR_W'(p);
  endfunction

  assign dly_in_eff = (delay_samples == '0) ? PTR_W'(1) : delay_samples;
  assign rd_ptr     = wr_ptr_q - dly_in_eff;
  assign hist_ok    = (fill_q >= {1'b0, dly_q});

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    dly_d         = dly_q;
    fill_d        = fill_q;
    byte_d        = byte_q;
    rdata_d       = rdata_q;
    save_en_d     = save_en_q;
    flush_pend_d  = flush_pend_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    past_output_d = past_output_q;
    good_data_d   = good_data_q;
    busy_d        = busy_q;
    overrun_d     = overrun_q;

    if (flush) begin
      overrun_d = 1'b0;
    end else if (sample_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // A flush seen mid-transaction is deferred to DONE so the bus stays legal.
    if (flush && (state_q != IDLE)) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // flush takes priority over a coincident sample_valid.
        if (flush) begin
          wr_ptr_d      = '0;
          fill_d        = '0;
          good_data_d   = 1'b0;
          past_output_d = AUDIO_ZERO;
        end else if (sample_valid) begin
          byte_d       = save_audio;
          save_en_d    = save_en;
          dly_d        = dly_in_eff;
          busy_d       = 1'b1;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = addr_of(rd_ptr);
          flush_pend_d = 1'b0;
          state_d      = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = save_en_q ? WR_REQ : DONE;
        end
      end
      WR_REQ: begin
        // First cycle here is the mandatory idle gap; request on the next.
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_of(wr_ptr_q);
          mem_wdata_d = byte_q;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (flush_pend_q || flush) begin
          wr_ptr_d      = '0;
          fill_d        = '0;
          good_data_d   = 1'b0;
          past_output_d = AUDIO_ZERO;
        end else begin
          good_data_d   = hist_ok;
          past_output_d = hist_ok ? rdata_q : AUDIO_ZERO;
          wr_ptr_d      = wr_ptr_q + PTR_W'(1);
          // fill never exceeds DEPTH, so its MSB alone marks saturation.
          if (save_en_q && !fill_q[PTR_W]) begin
            fill_d = fill_q + (PTR_W+1)'(1);
          end
        end
        flush_pend_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      dly_q         <= PTR_W'(1);
      fill_q        <= '0;
      byte_q        <= '0;
      rdata_q       <= '0;
      save_en_q     <= 1'b0;
      flush_pend_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= BASE_ADDR;
      mem_wdata_q   <= '0;
      past_output_q <= AUDIO_ZERO;
      good_data_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      dly_q         <= dly_d;
      fill_q        <= fill_d;
      byte_q        <= byte_d;
      rdata_q       <= rdata_d;
      save_en_q     <= save_en_d;
      flush_pend_q  <= flush_pend_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      past_output_q <= past_output_d;
      good_data_q   <= good_data_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign past_output = past_output_q;
  assign good_data   = good_data_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule
